// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI-Stream round-robin arbiter.
// rr_pick works on a 16-bit request vector; unused upper requests must be zero.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int MAX_SRC    = 16;

    // With req bits at and above N_SRC held at zero, a modulo-16 scan from ptr
    // picks the same winner as a modulo-N_SRC scan.
    function automatic logic [3:0] rr_pick(input logic [MAX_SRC-1:0] req, input logic [3:0] ptr);
        logic [3:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < MAX_SRC; i++) begin
            idx = ptr + 4'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered buffer carrying one concatenated stream beat per entry.
// The head register drives the output directly, so o_data is stable until popped.
module axis_skid_buf
    import axis_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == 2'(SKID_DEPTH));
    assign o_empty = (r_count == 2'd0);
    assign o_data  = r_head;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // NOTE: the data registers are reset too, because the output fields must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: r_head <= i_data;  // only reachable at count 1
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream output among N_SRC sources.
// A grant is held from the first beat until the tlast beat has been accepted.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_SRC-1:0]                 s_axis_tvalid,
    output logic [N_SRC-1:0]                 s_axis_tready,
    input  logic [N_SRC*DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [N_SRC*(DATA_WIDTH/8)-1:0]  s_axis_tstrb,
    input  logic [N_SRC*(DATA_WIDTH/8)-1:0]  s_axis_tkeep,
    input  logic [N_SRC-1:0]                 s_axis_tlast,
    input  logic [N_SRC*ID_WIDTH-1:0]        s_axis_tid,
    input  logic [N_SRC*DEST_WIDTH-1:0]      s_axis_tdest,
    input  logic [N_SRC*USER_WIDTH-1:0]      s_axis_tuser,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]          m_axis_tstrb,
    output logic [DATA_WIDTH/8-1:0]          m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic [DEST_WIDTH-1:0]            m_axis_tdest,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic [N_SRC-1:0]                 grant,
    output logic                             busy
);

    localparam int PTR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BEAT_W = DATA_WIDTH + 2 * STRB_W + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    arb_state_t        r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_g;
    logic [N_SRC-1:0]  r_grant;
    logic [PTR_W-1:0]  w_pick;
    logic [N_SRC-1:0]  w_pick_onehot;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [BEAT_W-1:0] w_sel_beat;
    logic [BEAT_W-1:0] w_out_beat;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_pick = PTR_W'(rr_pick(MAX_SRC'(s_axis_tvalid), 4'(r_ptr)));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_sel_valid   = 1'b0;
        w_sel_beat    = '0;
        w_pick_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_pick_onehot[i] = (w_pick == PTR_W'(i));
            if (r_g == PTR_W'(i)) begin
                w_sel_valid = s_axis_tvalid[i];
                w_sel_beat  = {s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH],
                               s_axis_tstrb[i*STRB_W +: STRB_W],
                               s_axis_tkeep[i*STRB_W +: STRB_W],
                               s_axis_tlast[i],
                               s_axis_tid[i*ID_WIDTH +: ID_WIDTH],
                               s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH],
                               s_axis_tuser[i*USER_WIDTH +: USER_WIDTH]};
            end
        end
    end

    assign w_sel_last    = w_sel_beat[ID_WIDTH + DEST_WIDTH + USER_WIDTH];
    assign w_push        = (r_state == BUSY) && w_sel_valid && !w_full;
    assign w_pop         = m_axis_tvalid && m_axis_tready;
    assign s_axis_tready = ((r_state == BUSY) && !w_full) ? r_grant : '0;
    assign grant         = r_grant;
    assign busy          = (r_state == BUSY);
    assign m_axis_tvalid = !w_empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_g     <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        r_state <= BUSY;
                        r_g     <= w_pick;
                        r_grant <= w_pick_onehot;
                    end
                end
                BUSY: begin
                    if (w_push && w_sel_last) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_ptr   <= (r_g == PTR_W'(N_SRC - 1)) ? '0 : r_g + PTR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    axis_skid_buf #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_sel_beat),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_empty (w_empty),
        .o_data  (w_out_beat)
    );

    assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
            m_axis_tid, m_axis_tdest, m_axis_tuser} = w_out_beat;

endmodule
